hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller: generates the flush/stall controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and by the PC.
- Detects load-use hazards from ID/EX versus IF/ID register addresses.
- Sequences branch-taken flushes and freezes the pipe during multi-cycle data-memory waits.
- Keeps saturating stall and flush statistics plus a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of the statistics counters.
- MEM_TIMEOUT, 255, maximum consecutive dmem_busy cycles before mem_err is set.
- BR_PENALTY, 1, number of cycles the flushes are held after a taken branch (1..3).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- id_ex_mem_read  input  1  ID/EX M-field mem-read bit.
- id_ex_rt  input  5  ID/EX destination register (instruction bits 20:16).
- if_id_rs  input  5  IF/ID instruction bits 25:21.
- if_id_rt  input  5  IF/ID instruction bits 20:16.
- if_id_uses_rt  input  1  decoded instruction reads rt.
- branch_taken  input  1  branch resolved taken (EX/MEM stage).
- dmem_busy  input  1  data memory not ready.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID load enable.
- if_id_flush  output  1  zero IF/ID.
- id_ex_flush  output  1  zero ID/EX control fields (drives the ID/EX flush input).
- ex_mem_flush  output  1  zero EX/MEM control fields.
- pipe_hold  output  1  ID/EX, EX/MEM, MEM/WB hold current contents.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.
- flush_cnt  output  CNT_W  saturating count of branch flush events.
- mem_err  output  1  sticky; busy exceeded MEM_TIMEOUT.

Behaviour:
- Control outputs are combinational from the current state and inputs, so a flush is visible before the posedge at which the pipeline registers sample it. Counters, mem_err, state and timers are registered.
- States: RUN, LD_STALL, MEM_WAIT, BR_FLUSH.
- Idle output values: pc_write=1, if_id_write=1, all flushes=0, pipe_hold=0.
- Reset (rst_n=0, async):
  - State goes to RUN; counters=0; mem_err=0; pending-branch flag=0; timers=0.
  - While rst_n is low: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, pipe_hold=0.
  - Reset mid-sequence abandons any stall, flush or pending branch.
- Priority in RUN: dmem_busy > branch_taken > load-use.
- load_use = id_ex_mem_read & (id_ex_rt!=0) & ((id_ex_rt==if_id_rs) | (if_id_uses_rt & id_ex_rt==if_id_rt)).
- RUN, load_use:
  - pc_write=0, if_id_write=0, id_ex_flush=1 in that cycle.
  - Next state LD_STALL; stall_cnt+1.
- LD_STALL:
  - Idle outputs; load-use is not re-evaluated, so the hazard cannot stall twice.
  - Exactly one bubble per load-use.
  - Next state RUN, or MEM_WAIT/BR_FLUSH by the RUN priority rules.
- RUN, branch_taken (no busy):
  - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1; flush_cnt+1.
  - If BR_PENALTY>1, go to BR_FLUSH for BR_PENALTY-1 further cycles with the same flush outputs; otherwise stay in RUN.
  - A load_use coincident with branch_taken is discarded.
- BR_FLUSH:
  - Down-counter runs to 0, then RUN.
  - branch_taken inputs are ignored, since they come from flushed slots.
- dmem_busy=1 in any non-reset state:
  - Enter or stay in MEM_WAIT.
  - Outputs: pc_write=0, if_id_write=0, pipe_hold=1, all flushes=0.
  - stall_cnt+1 per busy cycle.
  - branch_taken seen while busy sets the pending flag.
  - Busy counter increments and saturates at MEM_TIMEOUT+1; on reaching MEM_TIMEOUT+1, mem_err=1 (sticky until reset). The pipe stays frozen regardless.
- MEM_WAIT, dmem_busy=0:
  - If pending: that cycle acts as the RUN branch_taken case (flush, flush_cnt+1), then clear pending.
  - Else act as RUN (load-use checked).
  - Busy counter clears.
- Entering MEM_WAIT from LD_STALL or BR_FLUSH:
  - The BR_FLUSH remainder is dropped; its flushes are already complete in the frozen registers.
  - LD_STALL needs no resume.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release -> during reset pc_write=0, id_ex_flush=1, stall_cnt=0. First cycle after release: pc_write=1, all flushes=0.
- Load-use: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 for 2 cycles -> exactly 1 cycle with pc_write=0/id_ex_flush=1, then idle; stall_cnt=1.
- Load-use negatives:
  - id_ex_rt=0 with if_id_rs=0 -> no stall.
  - id_ex_rt=9, if_id_rt=9, if_id_uses_rt=0 -> no stall.
  - if_id_uses_rt=1 -> stall.
- Branch: branch_taken pulse with BR_PENALTY=1 -> 1 cycle of all three flushes with pc_write=1; flush_cnt=1. With BR_PENALTY=3 -> 3 flush cycles; flush_cnt=1.
- Busy with pending branch: dmem_busy=1 for 5 cycles, branch_taken=1 on cycle 2 -> 5 cycles of pipe_hold=1/no flush, then 1 flush cycle; stall_cnt=5, flush_cnt=1.
- Timeout: MEM_TIMEOUT=4, dmem_busy high for 6 cycles -> mem_err rises after the 5th busy cycle and stays 1 after busy drops, until rst_n=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Produces the PC / IF/ID load enables and the IF/ID, ID/EX and EX/MEM flush
// controls. It detects load-use hazards, sequences branch-taken flushes and
// freezes the pipe while data memory is busy. It also keeps saturating
// stall/flush statistics and a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int BR_PENALTY  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    BR_FLUSH = 2'd3
  } state_t;

  // Busy counter must be able to hold MEM_TIMEOUT+1, the saturation point.
  localparam int             BW         = $clog2(MEM_TIMEOUT + 2);
  localparam logic [BW-1:0]  BUSY_LIMIT = BW'(MEM_TIMEOUT + 1);
  localparam logic [1:0]     BR_RELOAD  = 2'(BR_PENALTY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_r, state_s;
  logic [1:0]        br_cnt_r, br_cnt_s;
  logic              pend_r, pend_s;
  logic [BW-1:0]     busy_cnt_r, busy_cnt_s;
  logic              mem_err_r, mem_err_s;
  logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
  logic              stall_inc_s, flush_inc_s;
  logic              load_use_s;
  logic              pc_write_s, if_id_write_s, if_id_flush_s;
  logic              id_ex_flush_s, ex_mem_flush_s, pipe_hold_s;

  assign load_use_s = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) ||
                       (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  // Next-state, timer and control-output decode from current state and inputs.
  always_comb begin
    state_s        = state_r;
    br_cnt_s       = br_cnt_r;
    pend_s         = pend_r;
    busy_cnt_s     = '0;
    mem_err_s      = mem_err_r;
    stall_inc_s    = 1'b0;
    flush_inc_s    = 1'b0;
    pc_write_s     = 1'b1;
    if_id_write_s  = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_flush_s = 1'b0;
    pipe_hold_s    = 1'b0;

    if (dmem_busy) begin
      // Freeze everything; any flush remainder is already held in frozen regs.
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      pipe_hold_s   = 1'b1;
      state_s       = MEM_WAIT;
      br_cnt_s      = 2'd0;
      stall_inc_s   = 1'b1;
      if (branch_taken) begin
        pend_s = 1'b1;
      end else begin
        pend_s = pend_r;
      end
      if (busy_cnt_r != BUSY_LIMIT) begin
        busy_cnt_s = busy_cnt_r + BW'(1);
      end else begin
        busy_cnt_s = busy_cnt_r;
      end
      if (busy_cnt_s == BUSY_LIMIT) begin
        mem_err_s = 1'b1;
      end else begin
        mem_err_s = mem_err_r;
      end
    end else begin
      case (state_r)
        BR_FLUSH: begin
          // Hold the flushes; branch_taken here comes from a flushed slot.
          if_id_flush_s  = 1'b1;
          id_ex_flush_s  = 1'b1;
          ex_mem_flush_s = 1'b1;
          if (br_cnt_r <= 2'd1) begin
            state_s  = RUN;
            br_cnt_s = 2'd0;
          end else begin
            br_cnt_s = br_cnt_r - 2'd1;
          end
        end
        RUN, LD_STALL, MEM_WAIT: begin
          // A pending branch only exists after a busy period (MEM_WAIT).
          if (branch_taken || pend_r) begin
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
            flush_inc_s    = 1'b1;
            pend_s         = 1'b0;
            if (BR_PENALTY > 1) begin
              state_s  = BR_FLUSH;
              br_cnt_s = BR_RELOAD;
            end else begin
              state_s  = RUN;
              br_cnt_s = 2'd0;
            end
          end else if (load_use_s && (state_r != LD_STALL)) begin
            // One bubble only: the hazard is not re-checked in LD_STALL.
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            id_ex_flush_s = 1'b1;
            stall_inc_s   = 1'b1;
            state_s       = LD_STALL;
          end else begin
            state_s = RUN;
          end
        end
        default: begin
          state_s = RUN;
        end
      endcase
    end
  end

  // State, branch timer, pending flag, busy timer and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RUN;
      br_cnt_r   <= 2'd0;
      pend_r     <= 1'b0;
      busy_cnt_r <= '0;
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      br_cnt_r   <= br_cnt_s;
      pend_r     <= pend_s;
      busy_cnt_r <= busy_cnt_s;
      mem_err_r  <= mem_err_s;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  // While in reset the pipe is held empty: no fetch, all stages flushed.
  assign pc_write     = rst_n & pc_write_s;
  assign if_id_write  = rst_n & if_id_write_s;
  assign if_id_flush  = ~rst_n | if_id_flush_s;
  assign id_ex_flush  = ~rst_n | id_ex_flush_s;
  assign ex_mem_flush = ~rst_n | ex_mem_flush_s;
  assign pipe_hold    = rst_n & pipe_hold_s;
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;
  assign mem_err      = mem_err_r;

endmodule
